svi_array_rr_mux: RTL

//  Round-robin N:1 merger that sits between an array of SVI handshake channels
//  and one SVI output channel.

---
 rtl/svi_array_rr_mux.sv | 63 ++++++
 1 files changed

// File: rtl/svi_array_rr_mux.sv
// N_CH:1 round-robin or fixed-priority merger into a registered one-entry output stage.
// Accepted beat is visible one edge after its handshake; a stalled sink holds data and drops every input ready.
module svi_array_rr_mux #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int GW   = $clog2(N_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         u_I_valid,
  input  logic [N_CH*WIDTH-1:0]   u_I_data,
  output logic [N_CH-1:0]         u_I_ready,
  output logic                    u_O_valid,
  output logic [WIDTH-1:0]        u_O_data,
  input  logic                    u_O_ready,
  output logic [GW-1:0]           o_grant,
  output logic                    o_busy
);

  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] win;
  logic [GW-1:0] cand;
  logic          any_valid;
  logic          load_en;
  logic          accept;

  // Search starts one past the last winner so the previous grantee goes last.
  always_comb begin
    win       = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = GW'((MODE == 1) ? (i - 1) : ((int'(rr_ptr) + i) % N_CH));
      if (!any_valid && u_I_valid[cand]) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  assign load_en   = !u_O_valid || u_O_ready;
  assign accept    = any_valid && load_en;
  assign u_I_ready = (i_rst_n && accept) ? (N_CH'(1) << win) : '0;
  assign o_busy    = u_O_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      u_O_valid <= 1'b0;
      u_O_data  <= '0;
      o_grant   <= '0;
      rr_ptr    <= GW'(N_CH - 1);
    end else if (accept) begin
      u_O_valid <= 1'b1;
      u_O_data  <= u_I_data[win*WIDTH +: WIDTH];
      o_grant   <= win;
      if (MODE == 0) rr_ptr <= win;
    end else if (u_O_ready) begin
      u_O_valid <= 1'b0;
    end
  end

endmodule
